conv_bram_1d_ctrl: RTL and testbench

Control engine that drives the 1-D convolution datapath from its input side. On a start pulse it sweeps the image BRAM column by column and issues one read per cycle. It generates the shift-register enable aligned to BRAM read latency, and generates result write address/enable pulses only at columns that complete a stride-aligned window. It then waits for the datapath's last_val and reports done.

---
 rtl/conv_1d_pkg.sv | 13 +
 rtl/conv_1d_rd_pipe.sv | 22 ++
 rtl/conv_bram_1d_ctrl.sv | 91 +++++++++
 tb/tb_conv_bram_1d_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_1d_pkg.sv
// conv_1d_pkg: shared FSM states and derived-size helpers for the 1-D convolution controller
package conv_1d_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    function automatic int result_w(input int img_w, input int filter_l, input int stride_w);
        return (img_w - filter_l) / stride_w + 1;
    endfunction
    function automatic int last_col(input int img_w, input int filter_l, input int stride_w);
        return (result_w(img_w, filter_l, stride_w) - 1) * stride_w + filter_l - 1;
    endfunction
    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_1d_rd_pipe.sv
// conv_1d_rd_pipe: two-stage delay turning a read strobe into the shift enable and result write enable
module conv_1d_rd_pipe (
    input  logic clk,
    input  logic reset,
    input  logic rd_valid,
    input  logic rd_flag,
    output logic sr_wren,
    output logic result_wren
);
    logic s1_flag;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_wren     <= 1'b0;
            s1_flag     <= 1'b0;
            result_wren <= 1'b0;
        end else begin
            sr_wren     <= rd_valid;
            s1_flag     <= rd_valid & rd_flag;
            result_wren <= s1_flag;
        end
    end
endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// conv_bram_1d_ctrl: sweeps the image BRAM one column per cycle and schedules datapath
// shift and result-write strobes for every stride-aligned complete window.
module conv_bram_1d_ctrl import conv_1d_pkg::*; #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1,
    localparam int RESULT_W              = result_w(IMG_W, FILTER_L, STRIDE_W),
    localparam int IMG_RAM_ADDR_WIDTH    = addr_w(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = addr_w(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             img_rden,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val
);
    localparam int PH_W = addr_w(STRIDE_W);
    localparam logic [IMG_RAM_ADDR_WIDTH-1:0]    LAST      = IMG_RAM_ADDR_WIDTH'(last_col(IMG_W, FILTER_L, STRIDE_W));
    localparam logic [IMG_RAM_ADDR_WIDTH-1:0]    FIRST_WIN = IMG_RAM_ADDR_WIDTH'(FILTER_L - 1);
    localparam logic [PH_W-1:0]                  PH_MAX    = PH_W'(STRIDE_W - 1);
    localparam logic [RESULT_RAM_ADDR_WIDTH-1:0] R_MAX     = RESULT_RAM_ADDR_WIDTH'(RESULT_W - 1);

    state_t                        state;
    logic [PH_W-1:0]               ph, ph_n;
    logic [IMG_RAM_ADDR_WIDTH-1:0] col_n;
    logic                          rd_flag, flag_n;

    assign busy = (state != IDLE);

    // Stride phase of the next column to be issued; restarts where the first full window lands.
    always_comb begin
        col_n  = (state == IDLE) ? '0 : img_rdaddr + 1'b1;
        ph_n   = (col_n == FIRST_WIN || ph == PH_MAX) ? '0 : ph + 1'b1;
        flag_n = (col_n >= FIRST_WIN) && (ph_n == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            done                <= 1'b0;
            img_rdaddr          <= '0;
            img_rden            <= 1'b0;
            rd_flag             <= 1'b0;
            ph                  <= '0;
            dpath_result_wraddr <= '0;
        end else begin
            done <= 1'b0;
            if (dpath_result_wren && dpath_result_wraddr != R_MAX)
                dpath_result_wraddr <= dpath_result_wraddr + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state               <= READ;
                    img_rden            <= 1'b1;
                    img_rdaddr          <= col_n;
                    ph                  <= ph_n;
                    rd_flag             <= flag_n;
                    dpath_result_wraddr <= '0;
                end
                READ: if (img_rdaddr == LAST) begin
                    state    <= DRAIN;
                    img_rden <= 1'b0;
                    rd_flag  <= 1'b0;
                end else begin
                    img_rdaddr <= col_n;
                    ph         <= ph_n;
                    rd_flag    <= flag_n;
                end
                DRAIN: if (last_val) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    conv_1d_rd_pipe u_pipe (
        .clk         (clk),
        .reset       (reset),
        .rd_valid    (img_rden),
        .rd_flag     (rd_flag),
        .sr_wren     (dpath_sr_wren),
        .result_wren (dpath_result_wren)
    );
endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// tb_conv_bram_1d_ctrl: randomized scoreboard bench over three geometries of the controller
module tb_conv_bram_1d_ctrl;
    typedef struct {int cyc; int val;} ev_t;

    localparam int IW [3] = '{32, 8, 4};
    localparam int FL [3] = '{3, 3, 4};
    localparam int SW [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0, last_val = '0;
    logic [2:0] busy, done, rden, srw, wren;
    logic [4:0] a0_rd, a0_wr;
    logic [2:0] a1_rd;
    logic [1:0] a1_wr, a2_rd;
    logic       a2_wr;
    int         rdaddr [3], wraddr [3];
    int         cyc = 0, ncmp = 0, nerr = 0;
    int         bfrom [3] = '{0, 0, 0}, bto [3] = '{0, 0, 0};
    ev_t        q [3][4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_bram_1d_ctrl #(.IMG_W(32), .FILTER_L(3), .STRIDE_W(1)) u0 (
        .clk(clk), .reset(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .img_rdaddr(a0_rd), .img_rden(rden[0]), .dpath_sr_wren(srw[0]),
        .dpath_result_wraddr(a0_wr), .dpath_result_wren(wren[0]), .last_val(last_val[0]));
    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(2)) u1 (
        .clk(clk), .reset(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .img_rdaddr(a1_rd), .img_rden(rden[1]), .dpath_sr_wren(srw[1]),
        .dpath_result_wraddr(a1_wr), .dpath_result_wren(wren[1]), .last_val(last_val[1]));
    conv_bram_1d_ctrl #(.IMG_W(4), .FILTER_L(4), .STRIDE_W(1)) u2 (
        .clk(clk), .reset(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .img_rdaddr(a2_rd), .img_rden(rden[2]), .dpath_sr_wren(srw[2]),
        .dpath_result_wraddr(a2_wr), .dpath_result_wren(wren[2]), .last_val(last_val[2]));

    always_comb begin
        rdaddr[0] = 32'(a0_rd);
        rdaddr[1] = 32'(a1_rd);
        rdaddr[2] = 32'(a2_rd);
        wraddr[0] = 32'(a0_wr);
        wraddr[1] = 32'(a1_wr);
        wraddr[2] = 32'(a2_wr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int kd, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q[k][kd].push_back(e);
    endtask

    // Reference: every column up to the last full stride-aligned window is read back to back.
    function automatic int last_column(input int k);
        int lc = FL[k] - 1;
        while (lc + SW[k] <= IW[k] - 1) lc += SW[k];
        return lc;
    endfunction

    task automatic model_reads(input int k, input int t);
        int r = 0;
        for (int c = 0; c <= last_column(k); c++) begin
            push(k, 0, t + 1 + c, c);
            push(k, 1, t + 2 + c, 0);
            if (c >= FL[k] - 1 && (c - FL[k] + 1) % SW[k] == 0) begin
                push(k, 2, t + 3 + c, r);
                r++;
            end
        end
    endtask

    task automatic do_pass(input int k, input bit hold);
        int t, l, spur;
        t = cyc;
        model_reads(k, t);
        l = t + 3 + last_column(k) + int'($urandom_range(0, 6));
        spur = ($urandom % 2 == 1) ? t + 1 + int'($urandom_range(0, last_column(k))) : -1;
        push(k, 3, l + 1, 0);
        bfrom[k] = t + 1;
        bto[k] = l + 1;
        start[k] = 1'b1;
        while (cyc < l) begin
            tick();
            start[k] = hold;
            last_val[k] = (cyc == spur);
        end
        start[k] = 1'b0;
        last_val[k] = 1'b1;
        tick();
        last_val[k] = 1'b0;
    endtask

    task automatic stream(input int k, input int kd, input bit pres, input int val, input string nm);
        ev_t e;
        while (q[k][kd].size() > 0 && q[k][kd][0].cyc < cyc) begin
            ncmp++;
            nerr++;
            $display("FAIL %s inst%0d missed: got none at cyc %0d, expected at cyc %0d val %0d",
                     nm, k, cyc, q[k][kd][0].cyc, q[k][kd][0].val);
            void'(q[k][kd].pop_front());
        end
        if (pres) begin
            ncmp++;
            if (q[k][kd].size() == 0 || q[k][kd][0].cyc != cyc) begin
                nerr++;
                $display("FAIL %s inst%0d unexpected strobe at cyc %0d val %0d, expected none", nm, k, cyc, val);
            end else begin
                e = q[k][kd].pop_front();
                if (e.val != val) begin
                    nerr++;
                    $display("FAIL %s inst%0d cyc %0d got %0d expected %0d", nm, k, cyc, val, e.val);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            stream(k, 0, rden[k], rdaddr[k], "img_rd");
            stream(k, 1, srw[k], 0, "sr_wren");
            stream(k, 2, wren[k], wraddr[k], "result_wr");
            stream(k, 3, done[k], 0, "done");
            ncmp++;
            if (busy[k] != (cyc >= bfrom[k] && cyc < bto[k])) begin
                nerr++;
                $display("FAIL busy inst%0d cyc %0d got %0b expected %0b", k, cyc, busy[k], !busy[k]);
            end
            if (!rst_n) begin
                ncmp++;
                if ({busy[k], done[k], rden[k], srw[k], wren[k]} != 5'b0 || rdaddr[k] != 0 || wraddr[k] != 0) begin
                    nerr++;
                    $display("FAIL reset_outs inst%0d cyc %0d got flags %b rd %0d wr %0d expected all 0",
                             k, cyc, {busy[k], done[k], rden[k], srw[k], wren[k]}, rdaddr[k], wraddr[k]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            last_val[k] = 1'b1;
            tick();
            last_val[k] = 1'b0;
            tick();
            do_pass(k, 1'b0);
            repeat (3) tick();
            do_pass(k, 1'b1);
            repeat (2) tick();
            do_pass(k, 1'b0);
            do_pass(k, 1'b0);
            repeat (4) begin
                do_pass(k, 1'($urandom % 2));
                if ($urandom % 2 == 1) repeat ($urandom_range(1, 4)) tick();
            end
            repeat (2) tick();
        end
        t = cyc;
        model_reads(0, t);
        bfrom[0] = t + 1;
        bto[0] = t + 10;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc < t + 10) tick();
        rst_n = 1'b0;
        for (int kd = 0; kd < 4; kd++)
            while (q[0][kd].size() > 0 && q[0][kd][q[0][kd].size() - 1].cyc >= t + 10)
                void'(q[0][kd].pop_back());
        repeat (2) tick();
        rst_n = 1'b1;
        while (cyc < t + 15) tick();
        do_pass(0, 1'b0);
        repeat (10) tick();
        for (int k = 0; k < 3; k++)
            for (int kd = 0; kd < 4; kd++) begin
                ncmp++;
                if (q[k][kd].size() != 0) begin
                    nerr++;
                    $display("FAIL leftover inst%0d stream%0d got %0d pending expected 0", k, kd, q[k][kd].size());
                end
            end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
